// File: rtl/tmds_par2ser_10to2.sv
// 10:2 TMDS gearbox: one-deep buffer + per-lane shift registers; bypass symbol shows bits[1:0] the cycle after the phase-4 edge.
// Backpressure: sym_ready drops on phases 0..3 while the holding buffer is full; starvation inserts IDLE_SYM.
module tmds_par2ser_10to2 #(
  parameter int          CHANNELS = 3,
  parameter logic [9:0]  IDLE_SYM = 10'b1101010100,
  parameter logic [9:0]  CLK_SYM  = 10'b0000011111
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  input  logic [10*CHANNELS-1:0]  sym_data,
  output logic [CHANNELS:0]       dout_h,
  output logic [CHANNELS:0]       dout_l,
  output logic                    dout_oe,
  output logic [2:0]              phase,
  output logic                    underflow,
  input  logic                    underflow_clr
);

  logic [2:0]               phase_q;
  logic                     buf_full;
  logic [10*CHANNELS-1:0]   buf_dat;
  logic [CHANNELS:0][9:0]   shreg;
  logic                     oe_q;
  logic                     uf_q;
  logic                     last;
  logic                     accept;
  logic                     uf_set;

  assign last      = (phase_q == 3'd4);
  assign sym_ready = !buf_full | last;
  assign accept    = sym_valid & sym_ready;
  // An idle slot only counts as underflow once the link is live.
  assign uf_set    = last & !buf_full & !sym_valid & oe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= 3'd0;
      buf_full <= 1'b0;
      buf_dat  <= '0;
      oe_q     <= 1'b0;
      uf_q     <= 1'b0;
      for (int n = 0; n < CHANNELS; n++) shreg[n] <= IDLE_SYM;
      shreg[CHANNELS] <= CLK_SYM;
    end else begin
      uf_q <= uf_set | (uf_q & !underflow_clr);
      if (last) begin
        phase_q         <= 3'd0;
        shreg[CHANNELS] <= CLK_SYM;
        if (buf_full) begin
          for (int n = 0; n < CHANNELS; n++) shreg[n] <= buf_dat[10*n +: 10];
          oe_q     <= 1'b1;
          buf_full <= accept;
          if (accept) buf_dat <= sym_data;
        end else if (accept) begin
          for (int n = 0; n < CHANNELS; n++) shreg[n] <= sym_data[10*n +: 10];
          oe_q <= 1'b1;
        end else begin
          for (int n = 0; n < CHANNELS; n++) shreg[n] <= IDLE_SYM;
        end
      end else begin
        phase_q <= phase_q + 3'd1;
        for (int n = 0; n <= CHANNELS; n++) shreg[n] <= shreg[n] >> 2;
        if (accept) begin
          buf_full <= 1'b1;
          buf_dat  <= sym_data;
        end
      end
    end
  end

  for (genvar n = 0; n <= CHANNELS; n++) begin : g_lane
    assign dout_h[n] = shreg[n][0];
    assign dout_l[n] = shreg[n][1];
  end

  assign dout_oe   = oe_q;
  assign phase     = phase_q;
  assign underflow = uf_q;

endmodule

// File: doc/tmds_par2ser_10to2.md
# tmds_par2ser_10to2

Gearbox between the TMDS encoders and the DDR output register. It runs in the 5x pixel (half-bit) clock and accepts one 10-bit TMDS symbol per data channel through a valid/ready handshake. Each symbol is buffered, then split into five 2-bit pairs: the posedge bit goes to `dout_h` and the negedge bit to `dout_l`. A fixed TMDS clock-channel pattern is generated alongside the data. The outputs drive the `datain_h` / `datain_l` / `oe` inputs of the downstream DDR output stage directly.

## Interface
- `CHANNELS`, 3, number of TMDS data channels; the clock channel is extra.
- `IDLE_SYM`, 10'b1101010100, symbol substituted on underflow (control token CTL=00).
- `CLK_SYM`, 10'b0000011111, clock-channel pattern, transmitted LSB first.
- `clk`  in  1  5x pixel clock; the only clock.
- `rst`  in  1  synchronous reset, active-high.
- `sym_valid`  in  1  `sym_data` holds one symbol for every data channel.
- `sym_ready`  out  1  block accepts `sym_data` on this edge if `sym_valid` is high.
- `sym_data`  in  10*CHANNELS  channel n in bits [10n+9:10n].
- `dout_h`  out  CHANNELS+1  posedge bits; bit CHANNELS is the clock channel.
- `dout_l`  out  CHANNELS+1  negedge bits; same mapping as `dout_h`.
- `dout_oe`  out  1  output enable for the DDR stage.
- `phase`  out  3  index (0..4) of the pair currently on `dout_h` / `dout_l`.
- `underflow`  out  1  sticky flag: a symbol slot was filled with `IDLE_SYM` while `dout_oe` was high.
- `underflow_clr`  in  1  synchronous clear of `underflow`.

## Operation
- **State:**
  - phase counter, 0..4, wraps 4->0.
  - one-deep holding buffer with a full flag.
  - per-channel 10-bit shift register.
  - `dout_oe` register.
  - `underflow` register.
- **Outputs:** `dout_h[n]` = shreg[n][0] and `dout_l[n]` = shreg[n][1]. They come straight from the registers, with no combinational path from the inputs.
- **Shift:** when phase != 4, each shreg shifts right by 2 and phase increments.
- **Load (edge where phase == 4):** phase goes to 0, and every shreg reloads from the first source that applies:
  - the buffer, if it is full; the buffer becomes empty unless refilled on the same edge.
  - otherwise, bypass from `sym_data` if the buffer is empty and `sym_valid` is high.
  - otherwise, `IDLE_SYM`. Underflow is set if `dout_oe` = 1.
  - The clock-channel shreg always reloads `CLK_SYM`.
- **Handshake:**
  - `sym_ready` = !buf_full | (phase == 4); it is combinational.
  - Accept = `sym_valid` & `sym_ready`.
  - If accept happens with the buffer full at phase 4, the buffer content goes to shreg and the new symbol goes to the buffer.
  - If accept happens with the buffer empty and phase != 4, the symbol goes to the buffer.
  - If accept happens with the buffer empty at phase 4, the symbol bypasses straight into shreg.
- **Output enable:** `dout_oe` goes high on the first load that takes a real (non-idle) symbol and stays high until `rst`.
- **Underflow flag:** `underflow` holds until `underflow_clr`. If set and clear occur on the same edge, set wins.

## Timing
- **Reset values:**
  - phase = 0
  - buffer empty
  - data shregs = `IDLE_SYM`
  - clock shreg = `CLK_SYM`
  - `dout_oe` = 0
  - `underflow` = 0
- During reset `sym_ready` evaluates to 1 but nothing is accepted. Reset asserted mid-symbol discards the buffer and the partial symbol.
- **Throughput:** one symbol per 5 clocks sustained. The buffer absorbs up to 4 cycles of upstream jitter.
- **Latency:** a symbol accepted by bypass at the phase-4 edge E has bits [1:0] on the outputs during the cycle after E. A buffered symbol appears after the next phase-4 edge.
- **Bit order:** LSB first. The pair at phase k is bits {2k+1, 2k}, with `dout_h` = bit 2k.
- **Clock channel:** the pattern gives h/l = 1/1, 1/1, 1/0, 0/0, 0/0 for phases 0..4.

## Test plan
- **Reset:** hold `rst` 3 cycles.
  - Required: `dout_oe` = 0, `underflow` = 0, phase = 0, `sym_ready` = 1.
  - Required: data pairs cycle through `IDLE_SYM` (h/l 0/0, 1/0, 1/0, 1/0, 1/1) with no underflow.
- **Bypass load:** present 0x2AB on all channels with `sym_valid` at phase 4.
  - Required: the next 5 cycles show h/l = 1/1, 0/1, 0/1, 0/1, 0/1.
  - Required: `dout_oe` rises with the first pair.
- **Back-to-back with buffer:** valid held high on a stream of 0x001, 0x3FF, 0x155.
  - Required: `sym_ready` = 0 on phases 0..3 once the buffer is full.
  - Required: the symbols serialize contiguously in order, with no idle inserted.
- **Underflow:** after `dout_oe` = 1, withhold `sym_valid` across a phase-4 edge.
  - Required: that slot carries `IDLE_SYM` and `underflow` = 1.
  - Required: `underflow_clr` clears it the next cycle; set and clear on the same edge leaves it at 1.
- **Mid-symbol reset:** assert `rst` at phase 2 with the buffer full.
  - Required: next cycle, phase = 0, buffer empty, `dout_oe` = 0, shregs at reset values.
- **Per-channel mapping:** drive CHANNELS = 3 with distinct symbols 0x001, 0x002, 0x200.
  - Required: a bit-accurate match of each lane.
  - Required: lane 3 always carries the `CLK_SYM` pattern.
